// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill controller.
// Holds line geometry constants and the refill FSM state encoding.
package icache_pkg;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
  localparam int OFFSET_BITS    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_BEAT,
    S_FILL,
    S_REPLAY
  } state_e;
endpackage

// File: rtl/icache_refill_ctrl_line_assembler.sv
// line_assembler: collects four 32-bit read beats into one 128-bit line.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   i_clear      - restart at word 0 (new line transfer accepted)
//   i_rvalid     - beat valid (already qualified by the caller)
//   i_rdata      - beat data, ascending word order
//   o_line       - assembled line, word 0 in bits [31:0]
//   o_last_beat  - current beat completes the line
module line_assembler
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_rvalid,
  input  logic [WORD_W-1:0] i_rdata,
  output logic [LINE_W-1:0] o_line,
  output logic              o_last_beat
);
  logic [1:0]                               r_beat;
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0]    r_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat <= '0;
      r_buf  <= '0;
    end else if (i_clear) begin
      r_beat <= '0;
    end else if (i_rvalid) begin
      r_buf[r_beat] <= i_rdata;
      r_beat        <= r_beat + 2'd1;
    end
  end

  assign o_line      = r_buf;
  assign o_last_beat = i_rvalid & (r_beat == 2'd3);
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss/refill controller between fetch, the 128-bit-line
// instruction cache and the word-wide memory port.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   i_fetch_valid, i_fetch_addr  - fetch request
//   o_fetch_stall                - instruction not yet valid, hold fetch
//   o_cache_addr, i_cache_hit    - cache lookup address / same-cycle result
//   o_cache_fill, o_cache_dataline - one-cycle line write
//   o_mem_req, o_mem_addr, i_mem_ack - line read request handshake
//   i_mem_rvalid, i_mem_rdata    - read beats
//   o_miss_count                 - saturating count of refills started
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MISS_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fetch_valid,
  input  logic [ADDR_W-1:0]     i_fetch_addr,
  output logic                  o_fetch_stall,
  output logic [ADDR_W-1:0]     o_cache_addr,
  input  logic                  i_cache_hit,
  output logic                  o_cache_fill,
  output logic [LINE_W-1:0]     o_cache_dataline,
  output logic                  o_mem_req,
  output logic [ADDR_W-1:0]     o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic                  i_mem_rvalid,
  input  logic [WORD_W-1:0]     i_mem_rdata,
  output logic [MISS_CNT_W-1:0] o_miss_count
);
  localparam logic [MISS_CNT_W-1:0] CNT_ONE = MISS_CNT_W'(1);

  state_e                  r_state, w_next;
  logic [ADDR_W-1:0]       r_miss_addr;
  logic [ADDR_W-1:0]       r_line_base;
  logic [MISS_CNT_W-1:0]   r_miss_count;
  logic                    w_miss_start;
  logic                    w_clear;
  logic                    w_rvalid;
  logic                    w_last_beat;
  logic [LINE_W-1:0]       w_line;

  // Beats are only accepted while a transfer is in flight; anything else
  // (stale beats from a reset-aborted transfer, early beats in REQ) is dropped.
  assign w_clear  = (r_state == S_REQ) & i_mem_ack;
  assign w_rvalid = (r_state == S_BEAT) & i_mem_rvalid;

  line_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_rvalid    (w_rvalid),
    .i_rdata     (i_mem_rdata),
    .o_line      (w_line),
    .o_last_beat (w_last_beat)
  );

  always_comb begin
    w_next        = r_state;
    o_fetch_stall = 1'b1;
    o_cache_addr  = r_miss_addr;
    w_miss_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cache_addr  = i_fetch_addr;
        o_fetch_stall = i_fetch_valid & ~i_cache_hit;
        if (i_fetch_valid & ~i_cache_hit) begin
          w_miss_start = 1'b1;
          w_next       = S_REQ;
        end
      end
      S_REQ:  if (i_mem_ack) w_next = S_BEAT;
      S_BEAT: if (w_last_beat) w_next = S_FILL;
      S_FILL: begin
        o_cache_addr = r_line_base;
        w_next       = S_REPLAY;
      end
      S_REPLAY: begin
        if (i_cache_hit) begin
          o_fetch_stall = 1'b0;
          w_next        = S_IDLE;
        end else begin
          // Line still absent after the fill: refetch the same line.
          w_miss_start = 1'b1;
          w_next       = S_REQ;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_miss_addr  <= '0;
      r_line_base  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_next;
      // Only a fresh miss from IDLE latches a new address; a replay miss
      // keeps refilling the original line.
      if (w_miss_start && r_state == S_IDLE) begin
        r_miss_addr <= i_fetch_addr;
        r_line_base <= {i_fetch_addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      end
      if (w_miss_start && r_miss_count != '1)
        r_miss_count <= r_miss_count + CNT_ONE;
    end
  end

  assign o_mem_req        = (r_state == S_REQ);
  assign o_mem_addr       = r_line_base;
  assign o_cache_fill     = (r_state == S_FILL);
  assign o_cache_dataline = w_line;
  assign o_miss_count     = r_miss_count;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;
  localparam int CW       = 4;
  localparam int CMAX_INT = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fv  = 1'b0;
  logic [31:0]  fa  = '0;
  logic         hit;
  logic         ack = 1'b0;
  logic         rv  = 1'b0;
  logic [31:0]  rd  = '0;

  logic          o_fetch_stall, o_cache_fill, o_mem_req;
  logic [31:0]   o_cache_addr, o_mem_addr;
  logic [127:0]  o_cache_dataline;
  logic [CW-1:0] o_miss_count;

  int vectors = 0;
  int errors  = 0;
  int exp_cnt = 0;

  logic [31:0] beat_d [4];
  int          gaps   [4];
  int          fills_seen = 0;
  bit          kill = 1'b0;

  // Behavioural direct-mapped cache: 64 lines, index addr[9:4], tag addr[31:10].
  // Line 0x40 starts out resident.
  logic [63:0]       m_vld = 64'h10;
  logic [63:0][21:0] m_tag = '0;

  icache_refill_ctrl #(.ADDR_W(32), .MISS_CNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_fetch_valid    (fv),
    .i_fetch_addr     (fa),
    .o_fetch_stall    (o_fetch_stall),
    .o_cache_addr     (o_cache_addr),
    .i_cache_hit      (hit),
    .o_cache_fill     (o_cache_fill),
    .o_cache_dataline (o_cache_dataline),
    .o_mem_req        (o_mem_req),
    .o_mem_addr       (o_mem_addr),
    .i_mem_ack        (ack),
    .i_mem_rvalid     (rv),
    .i_mem_rdata      (rd),
    .o_miss_count     (o_miss_count)
  );

  always #5 clk = ~clk;

  // kill forces the lookup after the first fill of a transaction to miss.
  always_comb
    hit = m_vld[o_cache_addr[9:4]] && (m_tag[o_cache_addr[9:4]] == o_cache_addr[31:10])
          && !(kill && fills_seen == 1);

  always @(posedge clk)
    if (o_cache_fill) begin
      m_vld[o_cache_addr[9:4]] <= 1'b1;
      m_tag[o_cache_addr[9:4]] <= o_cache_addr[31:10];
    end

  function automatic bit in_cache(input logic [31:0] a);
    return m_vld[a[9:4]] && (m_tag[a[9:4]] == a[31:10]);
  endfunction

  function automatic int sat_add(input int c, input int n);
    return (c + n > CMAX_INT) ? CMAX_INT : c + n;
  endfunction

  task automatic set_beats(input logic [31:0] d0, d1, d2, d3);
    beat_d[0] = d0; beat_d[1] = d1; beat_d[2] = d2; beat_d[3] = d3;
  endtask

  task automatic set_gaps(input int g0, g1, g2, g3);
    gaps[0] = g0; gaps[1] = g1; gaps[2] = g2; gaps[3] = g3;
  endtask

  // One fetch access with a reactive memory model. Expected stall length is
  // 7 cycles per refill plus every ack wait and beat gap; a forced replay miss
  // doubles the whole refill.
  task automatic access(input logic [31:0] a, input int ackw, input bit k, input string nm);
    int cyc, ack_cnt, beat, gcnt, exp_stall, fill_cyc, exp_fills;
    bit ack_done, exp_hit;
    logic [31:0]  base;
    logic [127:0] exp_line;
    base      = {a[31:4], 4'h0};
    exp_line  = {beat_d[3], beat_d[2], beat_d[1], beat_d[0]};
    exp_hit   = in_cache(a);
    exp_stall = exp_hit ? 0 : (7 + ackw + gaps[0] + gaps[1] + gaps[2] + gaps[3]) * (k ? 2 : 1);
    exp_fills = exp_hit ? 0 : (k ? 2 : 1);
    if (!exp_hit) exp_cnt = sat_add(exp_cnt, k ? 2 : 1);
    kill = k; fills_seen = 0;
    cyc = 0; ack_cnt = 0; beat = 0; gcnt = 0; ack_done = 0; fill_cyc = -1;
    @(negedge clk); fv = 1'b1; fa = a; ack = 1'b0; rv = 1'b0;
    #1;
    while (o_fetch_stall && cyc < 400) begin
      if (o_mem_req) begin
        vectors++;
        if (o_mem_addr !== base) begin
          errors++; $display("FAIL %s mem_addr got %h want %h", nm, o_mem_addr, base);
        end
      end
      if (o_cache_fill) begin
        fills_seen++; fill_cyc = cyc; vectors++;
        if (o_cache_dataline !== exp_line || o_cache_addr !== base) begin
          errors++;
          $display("FAIL %s fill line got %h @%h want %h @%h", nm, o_cache_dataline, o_cache_addr, exp_line, base);
        end
      end
      @(negedge clk); cyc++;
      fa = $urandom;  // fetch address wanders; the latched miss address must govern
      ack = 1'b0; rv = 1'b0; rd = $urandom;
      if (ack_done && beat < 4) begin
        if (gcnt < gaps[beat]) gcnt++;
        else begin rv = 1'b1; rd = beat_d[beat]; beat++; gcnt = 0; end
      end else begin
        rv = 1'($urandom_range(0, 1));  // stray beats must be ignored
      end
      if (o_mem_req) begin
        if (beat == 4) begin ack_done = 0; beat = 0; ack_cnt = 0; end
        if (ack_done) begin
          vectors++; errors++; $display("FAIL %s mem_req held after ack got 1 want 0", nm);
        end else if (ack_cnt == ackw) begin ack = 1'b1; ack_done = 1; end
        else ack_cnt++;
      end
      #1;
    end
    vectors++;
    if (cyc !== exp_stall) begin errors++; $display("FAIL %s stall_cycles got %0d want %0d", nm, cyc, exp_stall); end
    vectors++;
    if (fills_seen !== exp_fills) begin errors++; $display("FAIL %s fill_count got %0d want %0d", nm, fills_seen, exp_fills); end
    if (!exp_hit) begin
      vectors++;
      if (fill_cyc !== exp_stall - 1) begin errors++; $display("FAIL %s fill_cycle got %0d want %0d", nm, fill_cyc, exp_stall - 1); end
    end
    vectors++;
    if (o_cache_addr !== a) begin errors++; $display("FAIL %s release_addr got %h want %h", nm, o_cache_addr, a); end
    vectors++;
    if (o_mem_req !== 1'b0) begin errors++; $display("FAIL %s mem_req_at_release got %b want 0", nm, o_mem_req); end
    @(negedge clk); fv = 1'b0; ack = 1'b0; rv = 1'b0; kill = 1'b0;
    #1;
    vectors++;
    if (o_miss_count !== CW'(exp_cnt)) begin errors++; $display("FAIL %s miss_count got %0d want %0d", nm, o_miss_count, exp_cnt); end
  endtask

  task automatic test_reset;
    @(negedge clk); fv = 1'b1; fa = 32'h1234;
    #1;
    vectors++;
    if (o_fetch_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_eq got %b want 1", o_fetch_stall); end
    vectors++;
    if ({o_mem_req, o_cache_fill} !== 2'b00 || o_mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_mem got req=%b fill=%b addr=%h want 0 0 0", o_mem_req, o_cache_fill, o_mem_addr);
    end
    vectors++;
    if (o_cache_dataline !== 128'h0 || o_miss_count !== '0) begin
      errors++; $display("FAIL reset_regs got line=%h cnt=%0d want 0 0", o_cache_dataline, o_miss_count);
    end
    fv = 1'b0; #1;
    vectors++;
    if (o_fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got %b want 0", o_fetch_stall); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_hit;
    set_gaps(0, 0, 0, 0);
    access(32'h40, 0, 1'b0, "hit");
  endtask

  task automatic test_miss_zero_wait;
    set_beats(32'hA, 32'hB, 32'hC, 32'hD); set_gaps(0, 0, 0, 0);
    access(32'h1234, 0, 1'b0, "miss0");
  endtask

  task automatic test_wait_states;
    set_beats(32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004);
    set_gaps(0, 0, 2, 0);
    access(32'h2238, 3, 1'b0, "waits");
  endtask

  task automatic test_reset_mid;
    int nfill;
    nfill = 0;
    @(negedge clk); fv = 1'b1; fa = 32'h3458;
    @(negedge clk); ack = 1'b1; fa = $urandom;
    #1; nfill += int'(o_cache_fill);
    vectors++;
    if (o_mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req got %b want 1", o_mem_req); end
    @(negedge clk); ack = 1'b0; rv = 1'b1; rd = 32'hBAD0;
    #1; nfill += int'(o_cache_fill);
    @(negedge clk); rv = 1'b1; rd = 32'hBAD1;
    #1; nfill += int'(o_cache_fill);
    @(negedge clk); rst = 1'b1; fv = 1'b0; rv = 1'b1; rd = 32'hBAD2;
    #1; nfill += int'(o_cache_fill);
    @(negedge clk); rst = 1'b0; rv = 1'b1; rd = 32'hBAD3;
    exp_cnt = 0;
    #1;
    vectors++;
    if (o_mem_req !== 1'b0 || o_mem_addr !== 32'h0 || o_fetch_stall !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle got req=%b addr=%h stall=%b want 0 0 0", o_mem_req, o_mem_addr, o_fetch_stall);
    end
    vectors++;
    if (o_cache_dataline !== 128'h0 || o_miss_count !== '0) begin
      errors++; $display("FAIL rstmid_regs got line=%h cnt=%0d want 0 0", o_cache_dataline, o_miss_count);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rv = 1'b1; rd = $urandom;
      #1; nfill += int'(o_cache_fill);
    end
    @(negedge clk); rv = 1'b0;
    #1; nfill += int'(o_cache_fill);
    vectors++;
    if (nfill !== 0) begin errors++; $display("FAIL rstmid_nofill got %0d want 0", nfill); end
    set_beats(32'h55, 32'h66, 32'h77, 32'h88); set_gaps(0, 1, 0, 0);
    access(32'h3458, 0, 1'b0, "after_rst");
  endtask

  task automatic test_replay_miss;
    set_beats(32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003);
    set_gaps(0, 0, 0, 0);
    access(32'h4C0C, 1, 1'b1, "replay_miss");
  endtask

  task automatic test_saturation;
    int i;
    i = 0;
    set_gaps(0, 0, 0, 0);
    while (exp_cnt < CMAX_INT && i < 40) begin
      set_beats($urandom, $urandom, $urandom, $urandom);
      access(32'h2_0000 + 32'(i) * 32'h10, 0, 1'b0, "sat_fill");
      i++;
    end
    set_beats($urandom, $urandom, $urandom, $urandom);
    access(32'h3_0000, 0, 1'b0, "sat_hold");
    set_beats($urandom, $urandom, $urandom, $urandom);
    access(32'h3_0010, 0, 1'b1, "sat_hold_replay");
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      a = 32'h8000 + 32'($urandom_range(0, 15)) * 32'h10 + 32'($urandom_range(0, 3)) * 32'h4;
      set_beats($urandom, $urandom, $urandom, $urandom);
      set_gaps($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      access(a, $urandom_range(0, 3), $urandom_range(0, 7) == 0, "random");
    end
  endtask

  initial begin
    test_reset;
    test_hit;
    test_miss_zero_wait;
    test_wait_states;
    test_reset_mid;
    test_replay_miss;
    test_saturation;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
